// File: rtl/pong_match_ctrl_pkg.sv
// Shared types and constants for the pong match controller and its tick ramp.
package pong_pkg;

  localparam int SCORE_W = 4;
  localparam int TICK_W  = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    OVER  = 3'd3
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_L    = 2'd1;
  localparam logic [1:0] WIN_R    = 2'd2;

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Button/core event inputs and score/core-control outputs of the match controller.
interface pong_match_ctrl_if;
  import pong_pkg::*;

  logic               _i_start;
  logic               _i_hit;
  logic               _i_miss_l;
  logic               _i_miss_r;
  logic               _o_core_rst;
  logic [TICK_W-1:0]  _o_tick_len;
  logic [SCORE_W-1:0] _o_score_l;
  logic [SCORE_W-1:0] _o_score_r;
  logic [1:0]         _o_winner;
  logic [2:0]         _o_state;

  modport master (
    output _i_start, _i_hit, _i_miss_l, _i_miss_r,
    input  _o_core_rst, _o_tick_len, _o_score_l, _o_score_r, _o_winner, _o_state
  );

  modport slave (
    input  _i_start, _i_hit, _i_miss_l, _i_miss_r,
    output _o_core_rst, _o_tick_len, _o_score_l, _o_score_r, _o_winner, _o_state
  );

endinterface

// File: rtl/pong_tick_ramp.sv
// Tick-length register: reloads base, shortens by tick>>SPEEDUP_SHIFT per hit (floor MIN_TICK_LEN).
// Latency 1 cycle from hit/load; no backpressure. Ramp built only with PONG_MATCH_SPEEDUP_EN.
module pong_tick_ramp
  import pong_pkg::*;
#(
  parameter logic [TICK_W-1:0] BASE_TICK_LEN = 32'd3_000_000,
  parameter logic [TICK_W-1:0] MIN_TICK_LEN  = 32'd750_000,
  parameter int                SPEEDUP_SHIFT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_base,
  input  logic              hit,
  output logic [TICK_W-1:0] tick_len
);

`ifdef PONG_MATCH_SPEEDUP_EN
  logic [TICK_W-1:0] tick_q;
  logic [TICK_W-1:0] tick_dec;

  // tick >> shift is never larger than tick, so the subtraction cannot wrap
  always_comb begin
    tick_dec = tick_q - (tick_q >> SPEEDUP_SHIFT);
    if (tick_dec < MIN_TICK_LEN) begin
      tick_dec = MIN_TICK_LEN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= BASE_TICK_LEN;
    end else if (load_base) begin
      tick_q <= BASE_TICK_LEN;
    end else if (hit) begin
      tick_q <= tick_dec;
    end
  end

  assign tick_len = tick_q;
`else
  logic unused_ramp;
  assign unused_ramp = ^{clk, rst_n, load_base, hit, MIN_TICK_LEN, 32'(SPEEDUP_SHIFT)};
  assign tick_len    = BASE_TICK_LEN;
`endif

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve delay, rally scoring, winner detection, core reset and tick length.
// All outputs registered (1-cycle latency); no backpressure. Speed-up ramp via PONG_MATCH_SPEEDUP_EN.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter logic [TICK_W-1:0] BASE_TICK_LEN = 32'd3_000_000,
  parameter logic [TICK_W-1:0] MIN_TICK_LEN  = 32'd750_000,
  parameter int                SPEEDUP_SHIFT = 3,
  parameter int unsigned       SERVE_CYCLES  = 12_000_000,
  parameter int unsigned       WIN_SCORE     = 5
) (
  input  logic              _i_clk,
  input  logic              _i_rst_n,
  pong_match_ctrl_if.slave  bus
);

  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
  localparam logic [TICK_W-1:0]  SERVE_LOAD = TICK_W'(SERVE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [TICK_W-1:0]  serve_cnt_q, serve_cnt_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic [1:0]         winner_q, winner_d;
  logic               core_rst_q;
  logic               ramp_hit;
  logic               ramp_load;
  logic [TICK_W-1:0]  tick_len;

  always_ff @(posedge _i_clk or negedge _i_rst_n) begin
    if (!_i_rst_n) begin
      state_q     <= IDLE;
      serve_cnt_q <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      winner_q    <= WIN_NONE;
      core_rst_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
      core_rst_q  <= (state_d != RALLY);
    end
  end

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    ramp_hit    = 1'b0;
    unique case (state_q)
      IDLE, OVER: begin
        if (bus._i_start) begin
          score_l_d   = '0;
          score_r_d   = '0;
          winner_d    = WIN_NONE;
          serve_cnt_d = SERVE_LOAD;
          state_d     = SERVE;
        end
      end
      SERVE: begin
        if (serve_cnt_q == '0) begin
          state_d = RALLY;
        end else begin
          serve_cnt_d = serve_cnt_q - 1'b1;
        end
      end
      RALLY: begin
        // misses outrank a same-cycle hit; a double miss is a let
        if (bus._i_miss_l && bus._i_miss_r) begin
          serve_cnt_d = SERVE_LOAD;
          state_d     = SERVE;
        end else if (bus._i_miss_l || bus._i_miss_r) begin
          if (bus._i_miss_l) begin
            score_r_d = score_r_q + 1'b1;
          end else begin
            score_l_d = score_l_q + 1'b1;
          end
          if (score_l_d == WIN_S) begin
            winner_d = WIN_L;
            state_d  = OVER;
          end else if (score_r_d == WIN_S) begin
            winner_d = WIN_R;
            state_d  = OVER;
          end else begin
            serve_cnt_d = SERVE_LOAD;
            state_d     = SERVE;
          end
        end else begin
          ramp_hit = bus._i_hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outside RALLY the ramp sits at base, so every rally starts from BASE_TICK_LEN
  assign ramp_load = (state_q != RALLY);

  pong_tick_ramp #(
    .BASE_TICK_LEN (BASE_TICK_LEN),
    .MIN_TICK_LEN  (MIN_TICK_LEN),
    .SPEEDUP_SHIFT (SPEEDUP_SHIFT)
  ) u_ramp (
    .clk       (_i_clk),
    .rst_n     (_i_rst_n),
    .load_base (ramp_load),
    .hit       (ramp_hit),
    .tick_len  (tick_len)
  );

  assign bus._o_core_rst = core_rst_q;
  assign bus._o_tick_len = tick_len;
  assign bus._o_score_l  = score_l_q;
  assign bus._o_score_r  = score_r_q;
  assign bus._o_winner   = winner_q;
  assign bus._o_state    = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed match walk-through then random events, scoreboarded against a rule-level model.
module tb_pong_match_ctrl;

  localparam int BASE  = 64;
  localparam int MIN   = 16;
  localparam int SHIFT = 2;
  localparam int SERVE = 4;
  localparam int WIN   = 3;
`ifdef PONG_MATCH_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pong_match_ctrl_if bus();

  pong_match_ctrl #(
    .BASE_TICK_LEN (32'(BASE)),
    .MIN_TICK_LEN  (32'(MIN)),
    .SPEEDUP_SHIFT (SHIFT),
    .SERVE_CYCLES  (SERVE),
    .WIN_SCORE     (WIN)
  ) dut (
    ._i_clk   (clk),
    ._i_rst_n (rst_n),
    .bus      (bus)
  );

  typedef struct {
    int st;
    int crst;
    int tick;
    int sl;
    int sr;
    int win;
    bit chk_tick;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0 idle, 1 serve, 2 rally, 3 over; m_left = serve cycles still to run
  int m_phase, m_left, m_sl, m_sr, m_win, m_tick;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_left = 0; m_sl = 0; m_sr = 0; m_win = 0; m_tick = BASE;
  endfunction

  function automatic void model_step(input bit s, input bit h, input bit ml, input bit mr);
    int dec;
    if (m_phase == 0 || m_phase == 3) begin
      if (s) begin
        m_sl = 0; m_sr = 0; m_win = 0; m_left = SERVE; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_phase = 2; m_tick = BASE;
      end
    end else begin
      if (ml && mr) begin
        m_phase = 1; m_left = SERVE;
      end else if (ml || mr) begin
        if (ml) m_sr = m_sr + 1;
        else    m_sl = m_sl + 1;
        if (m_sl == WIN)      begin m_win = 1; m_phase = 3; end
        else if (m_sr == WIN) begin m_win = 2; m_phase = 3; end
        else                  begin m_phase = 1; m_left = SERVE; end
      end else if (h && SPEEDUP) begin
        dec    = m_tick - m_tick / (1 << SHIFT);
        m_tick = (dec < MIN) ? MIN : dec;
      end
    end
    if (m_phase == 0) m_tick = BASE;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st = m_phase; e.crst = (m_phase != 2) ? 1 : 0; e.tick = m_tick;
    e.sl = m_sl; e.sr = m_sr; e.win = m_win;
    e.chk_tick = (m_phase == 0 || m_phase == 2);
    return e;
  endfunction

  // One clock of stimulus: inputs applied at the falling edge, expectation queued for the next rising edge
  task automatic step(input bit r, input bit s, input bit h, input bit ml, input bit mr);
    @(negedge clk);
    rst_n = r;
    bus._i_start = s; bus._i_hit = h; bus._i_miss_l = ml; bus._i_miss_r = mr;
    if (!r) model_reset();
    else    model_step(s, h, ml, mr);
    sb.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  // Reset dropped between edges must clear outputs without waiting for a clock
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus._i_start = 0; bus._i_hit = 0; bus._i_miss_l = 0; bus._i_miss_r = 0;
    #1;
    chk("async_state",    int'(bus._o_state),    0);
    chk("async_core_rst", int'(bus._o_core_rst), 1);
    chk("async_tick",     int'(bus._o_tick_len), BASE);
    chk("async_score_l",  int'(bus._o_score_l),  0);
    chk("async_score_r",  int'(bus._o_score_r),  0);
    chk("async_winner",   int'(bus._o_winner),   0);
    model_reset();
    sb.push_back(model_out());
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("state",    int'(bus._o_state),    e.st);
        chk("core_rst", int'(bus._o_core_rst), e.crst);
        chk("score_l",  int'(bus._o_score_l),  e.sl);
        chk("score_r",  int'(bus._o_score_r),  e.sr);
        chk("winner",   int'(bus._o_winner),   e.win);
        if (e.chk_tick) chk("tick_len", int'(bus._o_tick_len), e.tick);
      end
    end
  end

  initial begin : driver
    bus._i_start = 0; bus._i_hit = 0; bus._i_miss_l = 0; bus._i_miss_r = 0;
    model_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // serve then rally; a start pulse mid-rally is ignored
    step(1, 1, 0, 0, 0);
    idle(SERVE);
    step(1, 1, 0, 0, 0);
    // seven returns walk the ramp down to its floor
    for (int i = 0; i < 7; i++) step(1, 0, 1, 0, 0);
    // left wins 3-0
    for (int i = 0; i < WIN; i++) begin
      step(1, 0, 0, 0, 1);
      if (i < WIN - 1) idle(SERVE);
    end
    step(1, 0, 0, 1, 0);
    idle(2);
    // restart, let, then hit colliding with a miss
    step(1, 1, 0, 0, 0);
    idle(SERVE);
    step(1, 0, 0, 1, 1);
    idle(SERVE);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 1, 0);
    idle(SERVE + 2);
    step(1, 0, 1, 0, 0);
    async_reset();
    step(1, 0, 0, 0, 0);
    // random phase
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else begin
        step(1, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
      end
    end
    idle(2);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
